video_probe_tap: RTL and testbench
==================================

VIDEO_PROBE_TAP -- requirements
Module: video_probe_tap

Interface
REQ-001 Parameter: VS_POL, 1, vsync active level (1 = active-high, 0 = active-low; input inverted internally when 0).
REQ-002 Parameter: HS_POL, 1, hsync active level, same rule as VS_POL.
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: vs_i  in  1  camera vertical sync.
REQ-006 Port: hs_i  in  1  camera horizontal sync.
REQ-007 Port: de_i  in  1  pixel data enable.
REQ-008 Port: rgb_i  in  24  pixel {R[7:0],G[7:0],B[7:0]}.
REQ-009 Port: pat_sel  in  1  test-pattern select; always present, used only per REQ-029.
REQ-010 Port: err_clr  in  1  single-cycle clear of line_err.
REQ-011 Port: probe0 / probe1 / probe2  out  1 each  normalised vs / hs / de.
REQ-012 Port: probe3  out  24  pixel coordinate {y[11:0], x[11:0]}.
REQ-013 Port: probe4  out  24  pixel data.
REQ-014 Port: frame_cnt  out  16  frames started since reset.
REQ-015 Port: line_err  out  1  sticky line-length mismatch flag.

Function
REQ-016 Stage 1 registers polarity-normalised vs, hs, de, rgb; stage 2 drives all probe outputs; probe0..probe4 lag inputs by exactly 2 cycles.
REQ-017 Rising/falling edges are detected on stage-1 signals versus their previous stage-1 value.
REQ-018 FSM states: WAIT_VS (after reset), IN_FRAME; WAIT_VS -> IN_FRAME on first vs rising edge; no other transitions except reset.
REQ-019 probe0..probe2 pass through in both states; in WAIT_VS probe3 = 0, probe4 = 0, counters and line checking inactive.
REQ-020 x: 12-bit; value attached to a pixel is the count of prior de cycles in the line (first pixel x = 0); saturates at 4095.
REQ-021 y: 12-bit; increments on de falling edge; saturates at 4095.
REQ-022 On vs rising edge: x = 0, y = 0, frame_cnt increments (wraps 0xFFFF -> 0x0000), reference length invalidated.
REQ-023 On de falling edge: x returns to 0; line length L = final x + 1.
REQ-024 First line of each frame stores L as reference; each later line with L != reference sets line_err.
REQ-025 line_err held until err_clr or reset; set and err_clr in same cycle -> line_err = 1.
REQ-026 de falling and vs rising in same cycle: line check performed for the ending line first, then REQ-022 applies (y = 0).
REQ-027 probe4 = pixel when stage-2 de = 1, else 24'h000000.

Reset
REQ-028 rst_n low asynchronously forces: state WAIT_VS, all probes 0, x = y = 0, frame_cnt = 0, line_err = 0, reference invalid, edge-detect history 0 (normalised); mid-frame reset discards partial frame.

Configuration
REQ-029 Macro VTAP_PATTERN_EN: when defined and pat_sel = 1 during IN_FRAME with de = 1, probe4 = colour bar with b = x[9:7], R = b[2] ? 8'hFF : 8'h00, G = b[1] ? 8'hFF : 8'h00, B = b[0] ? 8'hFF : 8'h00; pat_sel sampled with stage-1 timing; when undefined, pat_sel ignored and probe4 always follows REQ-027.

Verification
REQ-030 Reset, then 3 frames of 4 lines x 8 pixels, VS_POL = 1 -> frame_cnt = 3, probe3 for last pixel of each frame = {12'd3, 12'd7}, line_err = 0.
REQ-031 Frame whose line 2 has 7 pixels (others 8) -> line_err = 1 from de falling of line 2; err_clr pulse -> 0; err_clr coincident with a new mismatch -> stays 1.
REQ-032 rgb_i = 24'h123456 with de = 1 at cycle N -> probe4 = 24'h123456 at N+2; de = 0 -> probe4 = 0.
REQ-033 VS_POL = 0, vs_i driven low for one sync -> probe0 = 1 two cycles later, frame_cnt = 1.
REQ-034 de pulses before first vs -> probe3 = 0, line_err = 0, frame_cnt = 0; rst_n asserted mid-line -> all outputs 0 immediately.
REQ-035 VTAP_PATTERN_EN defined, pat_sel = 1, line of 1024 pixels -> probe4 = 24'h000000 for x 0..127, 24'h0000FF for x 128..255, ..., 24'hFFFFFF for x 896..1023; macro undefined -> probe4 follows rgb_i.

Source files
------------

// File: rtl/video_probe_tap.sv
// Two-stage video probe tap: polarity-normalised syncs, pixel coordinates, frame count and line-length check.
// Define VTAP_PATTERN_EN to let pat_sel replace probe4 with colour bars inside a frame.
module video_probe_tap #(
    parameter bit VS_POL = 1'b1,
    parameter bit HS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    input  logic        pat_sel,
    input  logic        err_clr,
    output logic        probe0,
    output logic        probe1,
    output logic        probe2,
    output logic [23:0] probe3,
    output logic [23:0] probe4,
    output logic [15:0] frame_cnt,
    output logic        line_err
);
    typedef enum logic {WAIT_VS, IN_FRAME} state_t;

    // Pixel counter saturates one above the largest x so a 4096+ pixel line still reports L = 4096.
    localparam logic [12:0] CNT_MAX = 13'd4096;

    state_t      state_q, state_d;
    logic        s1_vs_q, s1_hs_q, s1_de_q;
    logic [23:0] s1_rgb_q;
    logic        hist_vs_q, hist_de_q;
    logic [12:0] cnt_q, cnt_d;
    logic [12:0] ref_q, ref_d;
    logic        ref_vld_q, ref_vld_d;
    logic [11:0] y_q, y_d;
    logic [15:0] frame_q, frame_d;
    logic        err_q, err_d, err_set;
    logic        vs_rise, de_fall;
    logic [11:0] x_cur;
    logic [23:0] pix_cur, coord_cur, pix_src;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vs_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_de_q   <= 1'b0;
            s1_rgb_q  <= 24'h0;
            hist_vs_q <= 1'b0;
            hist_de_q <= 1'b0;
        end else begin
            s1_vs_q   <= (VS_POL != 1'b0) ? vs_i : ~vs_i;
            s1_hs_q   <= (HS_POL != 1'b0) ? hs_i : ~hs_i;
            s1_de_q   <= de_i;
            s1_rgb_q  <= rgb_i;
            hist_vs_q <= s1_vs_q;
            hist_de_q <= s1_de_q;
        end
    end

    assign vs_rise = s1_vs_q & ~hist_vs_q;
    assign de_fall = ~s1_de_q & hist_de_q;
    assign x_cur   = (cnt_q > 13'd4095) ? 12'hFFF : cnt_q[11:0];

`ifdef VTAP_PATTERN_EN
    logic       s1_pat_q;
    logic [2:0] bar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_pat_q <= 1'b0;
        else        s1_pat_q <= pat_sel;
    end

    assign bar     = x_cur[9:7];
    assign pix_src = s1_pat_q ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : s1_rgb_q;
`else
    logic unused_pat;
    assign unused_pat = pat_sel;
    assign pix_src    = s1_rgb_q;
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        pix_cur   = 24'h0;
        coord_cur = 24'h0;
        if (state_q == IN_FRAME) begin
            coord_cur = {y_q, x_cur};
            if (s1_de_q) pix_cur = pix_src;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        frame_d   = frame_q;
        err_set   = 1'b0;
        if (state_q == IN_FRAME) begin
            if (s1_de_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 13'd1;
            if (de_fall) begin
                cnt_d = 13'd0;
                if (y_q != 12'hFFF) y_d = y_q + 12'd1;
                if (ref_vld_q) begin
                    err_set = (cnt_q != ref_q);
                end else begin
                    ref_d     = cnt_q;
                    ref_vld_d = 1'b1;
                end
            end
        end
        // Frame start is applied after the line check so a coincident de fall is judged first.
        if (vs_rise) begin
            state_d   = IN_FRAME;
            cnt_d     = 13'd0;
            y_d       = 12'd0;
            ref_vld_d = 1'b0;
            frame_d   = frame_q + 16'd1;
        end
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_VS;
            cnt_q     <= 13'd0;
            y_q       <= 12'd0;
            ref_q     <= 13'd0;
            ref_vld_q <= 1'b0;
            frame_q   <= 16'd0;
            err_q     <= 1'b0;
            probe0    <= 1'b0;
            probe1    <= 1'b0;
            probe2    <= 1'b0;
            probe3    <= 24'h0;
            probe4    <= 24'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            probe0    <= s1_vs_q;
            probe1    <= s1_hs_q;
            probe2    <= s1_de_q;
            probe3    <= coord_cur;
            probe4    <= pix_cur;
        end
    end

    assign frame_cnt = frame_q;
    assign line_err  = err_q;
endmodule

// File: tb/tb_video_probe_tap.sv
// Self-checking bench for video_probe_tap: vector table, directed frame sequences and random traffic
// compared against a frame/line reference model; a second instance runs with inverted sync polarity.
module tb_video_probe_tap;
    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb;
        logic        pat;
    } smp_t;

    typedef struct {
        smp_t        in;
        logic [67:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, hs, de, pat, clr;
    logic [23:0] rgb;

    logic        a_p0, a_p1, a_p2, a_err, b_p0, b_p1, b_p2, b_err;
    logic [23:0] a_p3, a_p4, b_p3, b_p4;
    logic [15:0] a_fc, b_fc;

    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    video_probe_tap #(.VS_POL(1'b1), .HS_POL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .vs_i(vs), .hs_i(hs), .de_i(de), .rgb_i(rgb),
        .pat_sel(pat), .err_clr(clr), .probe0(a_p0), .probe1(a_p1), .probe2(a_p2),
        .probe3(a_p3), .probe4(a_p4), .frame_cnt(a_fc), .line_err(a_err)
    );

    video_probe_tap #(.VS_POL(1'b0), .HS_POL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .vs_i(~vs), .hs_i(~hs), .de_i(de), .rgb_i(rgb),
        .pat_sel(pat), .err_clr(clr), .probe0(b_p0), .probe1(b_p1), .probe2(b_p2),
        .probe3(b_p3), .probe4(b_p4), .frame_cnt(b_fc), .line_err(b_err)
    );

    function automatic logic [67:0] pk(input logic p0, input logic p1, input logic p2,
                                       input logic [23:0] p3, input logic [23:0] p4,
                                       input logic [15:0] fc, input logic err);
        return {p0, p1, p2, p3, p4, fc, err};
    endfunction

    function automatic smp_t mk(input logic v, input logic h, input logic d,
                                input logic [23:0] c, input logic p);
        smp_t s;
        s.vs = v; s.hs = h; s.de = d; s.rgb = c; s.pat = p;
        return s;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame/line bookkeeping with unbounded counts clipped at the edges.
    bit   m_in_frame, m_ref_vld, m_err, m_pv_vs, m_pv_de;
    int   m_count, m_y, m_ref, m_frame;
    smp_t pend;

    task automatic model_reset();
        m_in_frame = 0; m_ref_vld = 0; m_err = 0; m_pv_vs = 0; m_pv_de = 0;
        m_count = 0; m_y = 0; m_ref = 0; m_frame = 0;
        pend = '0;
    endtask

    task automatic model_apply(input smp_t s, input bit c, output logic [67:0] exp);
        bit          vs_edge, de_edge, set;
        int          x, len;
        logic [23:0] coord, pix;
        vs_edge = s.vs && !m_pv_vs;
        de_edge = !s.de && m_pv_de;
        x = (m_count > 4095) ? 4095 : m_count;
        coord = 24'h0;
        pix   = 24'h0;
        if (m_in_frame) begin
            coord = {m_y[11:0], x[11:0]};
            if (s.de) begin
                pix = s.rgb;
`ifdef VTAP_PATTERN_EN
                if (s.pat) begin
                    int b;
                    b = (x / 128) % 8;
                    pix = {(b & 4) ? 8'hFF : 8'h00, (b & 2) ? 8'hFF : 8'h00, (b & 1) ? 8'hFF : 8'h00};
                end
`endif
            end
        end
        set = 0;
        if (m_in_frame) begin
            if (s.de) m_count++;
            if (de_edge) begin
                len = (m_count > 4096) ? 4096 : m_count;
                if (m_ref_vld) set = (len != m_ref);
                else begin
                    m_ref = len;
                    m_ref_vld = 1;
                end
                m_count = 0;
                m_y = (m_y >= 4095) ? 4095 : m_y + 1;
            end
        end
        if (vs_edge) begin
            m_in_frame = 1; m_count = 0; m_y = 0; m_ref_vld = 0;
            m_frame = (m_frame + 1) % 65536;
        end
        m_err = set || (m_err && !c);
        m_pv_vs = s.vs;
        m_pv_de = s.de;
        exp = pk(s.vs, s.hs, s.de, coord, pix, m_frame[15:0], m_err);
    endtask

    logic [23:0] last_coord;
    int          max_x;
    bit          pat_mode;

    task automatic step(input smp_t s, input bit c);
        logic [67:0] exp;
        logic [23:0] pexp;
        int          x;
        vs = s.vs; hs = s.hs; de = s.de; rgb = s.rgb; pat = s.pat; clr = c;
        @(posedge clk);
        #1;
        model_apply(pend, c, exp);
        check("model_a", pk(a_p0, a_p1, a_p2, a_p3, a_p4, a_fc, a_err), exp);
        check("model_b", pk(b_p0, b_p1, b_p2, b_p3, b_p4, b_fc, b_err), exp);
        if (a_p2) begin
            last_coord = a_p3;
            if (int'(a_p3[11:0]) > max_x) max_x = int'(a_p3[11:0]);
            if (pat_mode && a_p3[6:0] == 7'd0) begin
                x = int'(a_p3[11:0]);
`ifdef VTAP_PATTERN_EN
                pexp = {{8{x[9]}}, {8{x[8]}}, {8{x[7]}}};
`else
                pexp = {12'hABC, x[11:0]};
`endif
                check("pattern_bar", {44'h0, a_p4}, {44'h0, pexp});
            end
        end
        pend = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 0, 0, 24'h0, 0), 0);
    endtask

    task automatic apply_reset();
        vs = 0; hs = 0; de = 0; rgb = 24'h0; pat = 0; clr = 0;
        rst_n = 1'b0;
        #13;
        check("reset_a", pk(a_p0, a_p1, a_p2, a_p3, a_p4, a_fc, a_err), 68'h0);
        check("reset_b", pk(b_p0, b_p1, b_p2, b_p3, b_p4, b_fc, b_err), 68'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        last_coord = 24'h0;
    endtask

    task automatic do_line(input int npix, input bit clr_end, input bit patl);
        step(mk(0, 1, 0, 24'h0, 0), 0);
        step(mk(0, 0, 0, 24'h0, 0), 0);
        for (int i = 0; i < npix; i++) begin
            if (patl) step(mk(0, 0, 1, {12'hABC, 12'(i)}, 1'b1), 0);
            else      step(mk(0, 0, 1, 24'($urandom), 1'b0), 0);
        end
        step(mk(0, 0, 0, 24'h0, 0), 0);
        step(mk(0, 0, 0, 24'h0, 0), clr_end);
    endtask

    task automatic do_frame(input int nlines, input int short_idx, input bit clr_short);
        step(mk(1, 0, 0, 24'h0, 0), 0);
        idle(2);
        for (int l = 0; l < nlines; l++)
            do_line((l == short_idx) ? 7 : 8, (l == short_idx) && clr_short, 1'b0);
        idle(3);
    endtask

    vec_t tv[8];

    initial begin
        bit de_state;
        pat_mode = 0;
        max_x = 0;
        apply_reset();

        // Pre-frame de/hs activity, first vs, first pixels and first line end.
        tv[0] = '{mk(0, 0, 1, 24'hAAAAAA, 0), pk(0, 0, 0, 24'h0, 24'h0, 16'd0, 0)};
        tv[1] = '{mk(0, 1, 0, 24'h0, 0),      pk(0, 0, 1, 24'h0, 24'h0, 16'd0, 0)};
        tv[2] = '{mk(1, 0, 0, 24'h0, 0),      pk(0, 1, 0, 24'h0, 24'h0, 16'd0, 0)};
        tv[3] = '{mk(0, 0, 1, 24'h123456, 0), pk(1, 0, 0, 24'h0, 24'h0, 16'd1, 0)};
        tv[4] = '{mk(0, 0, 1, 24'h654321, 0), pk(0, 0, 1, 24'h0, 24'h123456, 16'd1, 0)};
        tv[5] = '{mk(0, 0, 0, 24'h0, 0),      pk(0, 0, 1, {12'd0, 12'd1}, 24'h654321, 16'd1, 0)};
        tv[6] = '{mk(0, 0, 0, 24'h0, 0),      pk(0, 0, 0, {12'd0, 12'd2}, 24'h0, 16'd1, 0)};
        tv[7] = '{mk(0, 0, 0, 24'h0, 0),      pk(0, 0, 0, {12'd1, 12'd0}, 24'h0, 16'd1, 0)};
        for (int i = 0; i < 8; i++) begin
            step(tv[i].in, 0);
            check($sformatf("table_a[%0d]", i), pk(a_p0, a_p1, a_p2, a_p3, a_p4, a_fc, a_err), tv[i].exp);
            check($sformatf("table_b[%0d]", i), pk(b_p0, b_p1, b_p2, b_p3, b_p4, b_fc, b_err), tv[i].exp);
        end

        // Three clean frames of 4 lines x 8 pixels.
        apply_reset();
        for (int f = 1; f <= 3; f++) begin
            do_frame(4, -1, 0);
            check($sformatf("last_coord_f%0d", f), {44'h0, last_coord}, {44'h0, 12'd3, 12'd7});
        end
        check("frame_cnt_3", {52'h0, a_fc}, 68'd3);
        check("frame_cnt_3_b", {52'h0, b_fc}, 68'd3);
        check("line_err_clean", {67'h0, a_err}, 68'd0);

        // Short second line sets the sticky flag; a clear pulse drops it.
        do_frame(4, 1, 0);
        check("line_err_set", {67'h0, a_err}, 68'd1);
        step(mk(0, 0, 0, 24'h0, 0), 1);
        idle(1);
        check("line_err_cleared", {67'h0, a_err}, 68'd0);

        // Clear arriving in the same cycle as a new mismatch leaves the flag set.
        do_frame(4, 1, 1);
        check("line_err_set_wins", {67'h0, a_err}, 68'd1);
        step(mk(0, 0, 0, 24'h0, 0), 1);
        idle(1);

        // Colour-bar line of 1024 pixels.
        step(mk(1, 0, 0, 24'h0, 0), 0);
        idle(2);
        pat_mode = 1;
        do_line(1024, 0, 1'b1);
        pat_mode = 0;
        idle(2);

        // Over-long line saturates x.
        max_x = 0;
        step(mk(1, 0, 0, 24'h0, 0), 0);
        idle(2);
        do_line(4200, 0, 1'b0);
        check("x_saturates", 68'(max_x), 68'd4095);

        // Reset in the middle of a line clears outputs without waiting for a clock.
        step(mk(1, 0, 0, 24'h0, 0), 0);
        idle(2);
        for (int i = 0; i < 5; i++) step(mk(0, 0, 1, 24'($urandom), 0), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midline_reset_a", pk(a_p0, a_p1, a_p2, a_p3, a_p4, a_fc, a_err), 68'h0);
        check("midline_reset_b", pk(b_p0, b_p1, b_p2, b_p3, b_p4, b_fc, b_err), 68'h0);
        apply_reset();

        // Random sync/data traffic against the model.
        de_state = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) de_state = ~de_state;
            step(mk(($urandom_range(199) == 0), ($urandom_range(19) == 0), de_state,
                    24'($urandom), 1'($urandom_range(1))), ($urandom_range(29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
